fpa_scheduler: RTL and testbench
================================

FPA_SCHEDULER -- requirements
Module: fpa_scheduler

Interface
REQ-001 Parameter: LAT, 5, adder pipeline depth in load-advances (number of register stages in the adder).
REQ-002 Parameter: OP_STAGE, 3, adder stage whose register output feeds the add/subtract logic, which consumes op combinationally.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 clear  in  1  synchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester n presents an operation.
REQ-006 req0_ready / req1_ready  out  1  scheduler accepts requester n this cycle.
REQ-007 req0_exp / req1_exp  in  16  two packed 8-bit exponents.
REQ-008 req0_mant / req1_mant  in  48  two packed 24-bit mantissas.
REQ-009 req0_op / req1_op  in  1  0 = add, 1 = subtract.
REQ-010 res_valid  out  1  result present; res_ready  in  1  consumer accepts.
REQ-011 res_id  out  1  originating requester; res_exp  out  8; res_mant  out  24.
REQ-012 adr_exps  out  16; adr_mants  out  48; adr_op  out  1; adr_load  out  1; adr_clear  out  1 (active-high): adder control.
REQ-013 adr_rez_exp  in  8; adr_rez_mant  in  24: adder final-stage outputs.
REQ-014 busy  out  1  any operation in flight; ops_done  out  16  completed-result counter.

Function
REQ-015 Shadow pipeline S1..S_LAT SHALL hold, per stage, {valid, id, op} and SHALL advance exactly when adr_load=1, in lockstep with the adder registers.
REQ-016 stall = S_LAT.valid & ~res_ready; adr_load SHALL equal ~stall while clear=1.
REQ-017 Arbitration: round-robin with last-served pointer; if only one req valid it is granted; if both valid, the one not last served is granted.
REQ-018 req_n_ready SHALL be 1 only for the granted requester, only when ~stall and clear=1; at most one ready high per cycle.
REQ-019 Transfer = valid & ready; on transfer, S1 SHALL load {1, n, req_n_op} and the last-served pointer SHALL become n.
REQ-020 With no transfer and ~stall, S1 SHALL load a bubble {0, 0, 0}.
REQ-021 adr_exps/adr_mants SHALL be muxed from the granted requester on transfer and SHALL be zero otherwise.
REQ-022 adr_op SHALL equal S_OP_STAGE.op, aligning op with the stage that consumes it.
REQ-023 res_valid = S_LAT.valid; res_id = S_LAT.id; res_exp/res_mant pass through adr_rez_exp/adr_rez_mant.
REQ-024 Latency: a transfer at edge E with no stalls SHALL yield res_valid=1 in the cycle after edge E+LAT-1 (LAT advancing edges, including E).
REQ-025 During a stall, all shadow state and all adder data SHALL hold, and no requester SHALL be accepted.
REQ-026 A result with res_valid & ~res_ready SHALL keep res_id/res_exp/res_mant stable until accepted.
REQ-027 ops_done SHALL increment on res_valid & res_ready, wrapping from 0xFFFF to 0x0000.
REQ-028 busy = OR of all shadow valid bits.
REQ-029 Requester behaviour: a requester SHALL hold its data stable while valid=1 & ready=0; the scheduler does not check this.

Reset
REQ-030 While clear=0: adr_clear=1, adr_load=0, both readys 0, res_valid 0, adr_op 0, and adr_exps/adr_mants zero.
REQ-031 On an edge with clear=0: all shadow bits clear, last-served pointer = 1 (requester 0 wins the first tie), ops_done = 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operations without producing a result; busy=0 on the cycle after reset.
REQ-033 When clear=1, adr_clear SHALL be 0.

Verification
REQ-034 Single op: after reset, req0 op=0 at edge 0, res_ready=1 -> res_valid=1 after edge 4, res_id=0, data matches a standalone adder run, ops_done=1.
REQ-035 Op alignment: back-to-back req0 op=0, op=1, op=0 -> adr_op sequence tracks S3, and each result matches its own op.
REQ-036 Contention: both requesters valid continuously for 6 cycles -> grants 0,1,0,1,0,1; res_id sequence identical; no bubbles.
REQ-037 Backpressure: res_ready=0 for 3 cycles while S5 is valid -> adr_load=0 and both readys 0 for 3 cycles; result held stable; order preserved after release.
REQ-038 Wrap and reset: preload ops_done to 0xFFFF via 65535 completions, one more completion -> 0x0000; clear=0 with 3 ops in flight -> no res_valid, busy=0 next cycle.

Source files
------------

// File: rtl/fpa_scheduler.sv
// ============================================================================
// fpa_scheduler
//
// Purpose
//   Two-requester front end for a multi-stage floating-point adder. It picks
//   one requester per cycle (round-robin), launches the operands into the
//   adder, and carries a shadow pipeline of {valid, id, op} next to the
//   adder's own registers. The add/subtract select is taken from the shadow
//   stage that lines up with the adder's arithmetic stage. When the last
//   stage holds a result the consumer has not taken, the whole pipe freezes.
//
// Ports
//   clk                      rising-edge clock
//   clear                    synchronous reset, active low
//   reqN_valid / reqN_ready  requester N handshake (N = 0, 1)
//   reqN_exp  [15:0]         two packed 8-bit exponents
//   reqN_mant [47:0]         two packed 24-bit mantissas
//   reqN_op                  0 = add, 1 = subtract
//   res_valid / res_ready    result handshake
//   res_id                   requester that issued the result
//   res_exp [7:0], res_mant [23:0]   result data (adder final stage)
//   adr_exps, adr_mants      operands into the adder (zero when nothing issues)
//   adr_op                   add/subtract select for the adder's op stage
//   adr_load                 adder stage enable
//   adr_clear                adder clear, active high
//   adr_rez_exp, adr_rez_mant  adder final-stage outputs
//   busy                     some operation is in flight
//   ops_done [15:0]          completed-result counter (wraps)
// ============================================================================
module fpa_scheduler #(
    parameter int LAT      = 5,
    parameter int OP_STAGE = 3
) (
    input  logic        clk,
    input  logic        clear,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_exp,
    input  logic [47:0] req0_mant,
    input  logic        req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_exp,
    input  logic [47:0] req1_mant,
    input  logic        req1_op,

    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
    output logic [7:0]  res_exp,
    output logic [23:0] res_mant,

    output logic [15:0] adr_exps,
    output logic [47:0] adr_mants,
    output logic        adr_op,
    output logic        adr_load,
    output logic        adr_clear,
    input  logic [7:0]  adr_rez_exp,
    input  logic [23:0] adr_rez_mant,

    output logic        busy,
    output logic [15:0] ops_done
);

    // Shadow pipeline, stage 1 .. LAT, one bit per stage per field.
    logic [LAT:1] s_valid_q, s_valid_d;
    logic [LAT:1] s_id_q,    s_id_d;
    logic [LAT:1] s_op_q,    s_op_d;

    logic         last_q, last_d;       // requester served most recently
    logic [15:0]  ops_done_q, ops_done_d;

    logic         stall;
    logic         advance;
    logic         any_req;
    logic         grant;
    logic         xfer;
    logic         res_fire;
    logic         in_valid;
    logic         in_id;
    logic         in_op;

    // ------------------------------------------------------------------
    // Flow control and arbitration
    // ------------------------------------------------------------------
    // Only an untaken result in the final stage can block the pipe; every
    // other stage always has somewhere to go when the pipe moves.
    assign stall   = s_valid_q[LAT] & ~res_ready;
    assign advance = clear & ~stall;
    assign any_req = req0_valid | req1_valid;

    // On a tie the requester that was not served last wins; otherwise the
    // lone valid requester wins. With no request, grant is don't-care and
    // is masked by any_req below.
    assign grant = (req0_valid & req1_valid) ? ~last_q : req1_valid;

    assign xfer       = advance & any_req;
    assign req0_ready = xfer & ~grant;
    assign req1_ready = xfer &  grant;

    // ------------------------------------------------------------------
    // Adder control
    // ------------------------------------------------------------------
    assign adr_load  = advance;
    assign adr_clear = ~clear;
    assign adr_exps  = xfer ? (grant ? req1_exp  : req0_exp)  : 16'd0;
    assign adr_mants = xfer ? (grant ? req1_mant : req0_mant) : 48'd0;
    // The op bit rides the shadow pipe and is presented while the matching
    // operands sit in the adder register that feeds its arithmetic.
    assign adr_op    = clear & s_op_q[OP_STAGE];

    // ------------------------------------------------------------------
    // Result side
    // ------------------------------------------------------------------
    assign res_valid = clear & s_valid_q[LAT];
    assign res_id    = s_id_q[LAT];
    assign res_exp   = adr_rez_exp;
    assign res_mant  = adr_rez_mant;
    assign res_fire  = res_valid & res_ready;

    assign busy     = |s_valid_q;
    assign ops_done = ops_done_q;

    // ------------------------------------------------------------------
    // Shadow pipeline next state: shift on advance, hold otherwise
    // ------------------------------------------------------------------
    // A cycle that advances without a transfer injects a bubble {0,0,0}.
    assign in_valid = xfer;
    assign in_id    = xfer & grant;
    assign in_op    = xfer & (grant ? req1_op : req0_op);

    generate
        for (genvar gi = 1; gi <= LAT; gi++) begin : g_shadow
            if (gi == 1) begin : g_head
                assign s_valid_d[gi] = advance ? in_valid : s_valid_q[gi];
                assign s_id_d[gi]    = advance ? in_id    : s_id_q[gi];
                assign s_op_d[gi]    = advance ? in_op    : s_op_q[gi];
            end else begin : g_body
                assign s_valid_d[gi] = advance ? s_valid_q[gi-1] : s_valid_q[gi];
                assign s_id_d[gi]    = advance ? s_id_q[gi-1]    : s_id_q[gi];
                assign s_op_d[gi]    = advance ? s_op_q[gi-1]    : s_op_q[gi];
            end
        end
    endgenerate

    assign last_d     = xfer ? grant : last_q;
    assign ops_done_d = ops_done_q + {15'd0, res_fire};

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Reset drops everything in flight; the pointer starts at requester 1
    // so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!clear) begin
            s_valid_q  <= '0;
            s_id_q     <= '0;
            s_op_q     <= '0;
            last_q     <= 1'b1;
            ops_done_q <= 16'd0;
        end else begin
            s_valid_q  <= s_valid_d;
            s_id_q     <= s_id_d;
            s_op_q     <= s_op_d;
            last_q     <= last_d;
            ops_done_q <= ops_done_d;
        end
    end

endmodule

// File: tb/tb_fpa_scheduler.sv
// ============================================================================
// tb_fpa_scheduler
//
// Self-checking bench for fpa_scheduler. A small behavioural adder (five
// register stages, arithmetic between stages 3 and 4 using adr_op) closes the
// loop. Every accepted request pushes its expected result onto a scoreboard;
// every accepted result is popped and compared in order. Scenario tasks add
// their own cycle-exact checks of handshakes, latency, alignment and stalls.
// ============================================================================
module tb_fpa_scheduler;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        clear;
    logic        req0_valid, req0_ready, req0_op;
    logic [15:0] req0_exp;
    logic [47:0] req0_mant;
    logic        req1_valid, req1_ready, req1_op;
    logic [15:0] req1_exp;
    logic [47:0] req1_mant;
    logic        res_valid, res_ready, res_id;
    logic [7:0]  res_exp;
    logic [23:0] res_mant;
    logic [15:0] adr_exps;
    logic [47:0] adr_mants;
    logic        adr_op, adr_load, adr_clear;
    logic [7:0]  adr_rez_exp;
    logic [23:0] adr_rez_mant;
    logic        busy;
    logic [15:0] ops_done;

    always #5 clk = ~clk;

    fpa_scheduler #(.LAT(LAT), .OP_STAGE(3)) dut (
        .clk          (clk),
        .clear        (clear),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_exp     (req0_exp),
        .req0_mant    (req0_mant),
        .req0_op      (req0_op),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_exp     (req1_exp),
        .req1_mant    (req1_mant),
        .req1_op      (req1_op),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_exp      (res_exp),
        .res_mant     (res_mant),
        .adr_exps     (adr_exps),
        .adr_mants    (adr_mants),
        .adr_op       (adr_op),
        .adr_load     (adr_load),
        .adr_clear    (adr_clear),
        .adr_rez_exp  (adr_rez_exp),
        .adr_rez_mant (adr_rez_mant),
        .busy         (busy),
        .ops_done     (ops_done)
    );

    // ------------------------------------------------------------------
    // Reference arithmetic: operand A in the low half, B in the high half.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_exp(input logic [15:0] e);
        return (e[7:0] > e[15:8]) ? e[7:0] : e[15:8];
    endfunction

    function automatic logic [23:0] f_mant(input logic [47:0] m, input logic op);
        return op ? (m[23:0] - m[47:24]) : (m[23:0] + m[47:24]);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural adder: 5 stages, op consumed on stage-3 output.
    // ------------------------------------------------------------------
    logic [15:0] ae1, ae2, ae3;
    logic [47:0] am1, am2, am3;
    logic [7:0]  ae4, ae5;
    logic [23:0] am4, am5;

    always @(posedge clk) begin
        if (adr_clear) begin
            ae1 <= '0; ae2 <= '0; ae3 <= '0; ae4 <= '0; ae5 <= '0;
            am1 <= '0; am2 <= '0; am3 <= '0; am4 <= '0; am5 <= '0;
        end else if (adr_load) begin
            ae1 <= adr_exps;   am1 <= adr_mants;
            ae2 <= ae1;        am2 <= am1;
            ae3 <= ae2;        am3 <= am2;
            ae4 <= f_exp(ae3); am4 <= f_mant(am3, adr_op);
            ae5 <= ae4;        am5 <= am4;
        end
    end

    assign adr_rez_exp  = ae5;
    assign adr_rez_mant = am5;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        id;
        logic [7:0]  e;
        logic [23:0] m;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    bit   quiet  = 1'b0;

    always @(negedge clk) begin
        res_t exp_r;
        if (!clear) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got id=%0d exp=%h mant=%h, required no result",
                             res_id, res_exp, res_mant);
                end else begin
                    exp_r = sb.pop_front();
                    if ({res_id, res_exp, res_mant} !== {exp_r.id, exp_r.e, exp_r.m}) begin
                        errors++;
                        $display("FAIL sb_result: got id=%0d exp=%h mant=%h, required id=%0d exp=%h mant=%h",
                                 res_id, res_exp, res_mant, exp_r.id, exp_r.e, exp_r.m);
                    end else if (!quiet) begin
                        $display("result id=%0d exp=%h mant=%h ok", res_id, res_exp, res_mant);
                    end
                end
            end
            if (req0_valid && req0_ready) begin
                sb.push_back('{1'b0, f_exp(req0_exp), f_mant(req0_mant, req0_op)});
                n_xfer++;
                if (!quiet) $display("issue req0 exp=%h mant=%h op=%0d", req0_exp, req0_mant, req0_op);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{1'b1, f_exp(req1_exp), f_mant(req1_mant, req1_op)});
                n_xfer++;
                if (!quiet) $display("issue req1 exp=%h mant=%h op=%0d", req1_exp, req1_mant, req1_op);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers (stimulus only)
    // ------------------------------------------------------------------
    task automatic rand_req0();
        req0_exp  = 16'($urandom);
        req0_mant = {16'($urandom), 32'($urandom)};
        req0_op   = 1'($urandom);
    endtask

    task automatic rand_req1();
        req1_exp  = 16'($urandom);
        req1_mant = {16'($urandom), 32'($urandom)};
        req1_op   = 1'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clear = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        clear = 1'b0; res_ready = 1'b1;
        rand_req0(); rand_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (adr_clear !== 1'b1) begin errors++; $display("FAIL reset_adr_clear: got %b, required 1", adr_clear); end
        checks++; if (adr_load !== 1'b0) begin errors++; $display("FAIL reset_adr_load: got %b, required 0", adr_load); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b%b, required 00", req0_ready, req1_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b, required 0", res_valid); end
        checks++; if (adr_op !== 1'b0) begin errors++; $display("FAIL reset_adr_op: got %b, required 0", adr_op); end
        checks++; if ({adr_exps, adr_mants} !== 64'd0) begin errors++; $display("FAIL reset_adr_data: got %h/%h, required 0", adr_exps, adr_mants); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done: got %h, required 0000", ops_done); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        checks++; if (adr_clear !== 1'b0) begin errors++; $display("FAIL run_adr_clear: got %b, required 0", adr_clear); end
        checks++; if (adr_load !== 1'b1) begin errors++; $display("FAIL run_adr_load: got %b, required 1", adr_load); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        req0_exp = 16'h3A51; req0_mant = 48'h00_1234_0A_BCDE; req0_op = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b%b, required 10", req0_ready, req1_ready); end
        @(posedge clk); #1;                 // edge 0: transfer
        req0_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);                 // after edge i
            checks++;
            if (res_valid !== 1'(i == LAT - 1)) begin
                errors++;
                $display("FAIL single_latency: after edge %0d res_valid=%b, required %b", i, res_valid, 1'(i == LAT - 1));
            end
        end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id: got %0d, required 0", res_id); end
        checks++; if ({res_exp, res_mant} !== {8'h51, 24'h1234 + 24'h0ABCDE}) begin
            errors++; $display("FAIL single_data: got %h/%h, required 51/%h", res_exp, res_mant, 24'h1234 + 24'h0ABCDE);
        end
        @(negedge clk);
        checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL single_ops_done: got %h, required 0001", ops_done); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain: res_valid=%b, required 0", res_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_op_align();
        logic [2:0] ops;
        logic       exp_op;
        ops = 3'b010;                       // ops[k] is the op of transfer k
        rand_req0(); req0_op = ops[0]; req0_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;             // edge c
            if (c < 2) begin
                rand_req0(); req0_op = ops[c + 1];
            end else begin
                req0_valid = 1'b0;
            end
            @(negedge clk);
            exp_op = (c >= 2 && c <= 4) ? ops[c - 2] : 1'b0;
            checks++;
            if (adr_op !== exp_op) begin
                errors++;
                $display("FAIL op_align: after edge %0d adr_op=%b, required %b", c, adr_op, exp_op);
            end
        end
        wait_idle();
    endtask

    task automatic test_contention();
        do_reset();
        rand_req0(); rand_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);                 // before edge c
            if (c < 6) begin
                checks++;
                if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL contention_grant: cycle %0d ready=%b%b, required grant %0d", c, req0_ready, req1_ready, c % 2);
                end
            end
            if (c >= 1) begin
                checks++;
                if (res_valid !== 1'(c >= 5 && c <= 10)) begin
                    errors++;
                    $display("FAIL contention_bubble: after edge %0d res_valid=%b, required %b", c - 1, res_valid, 1'(c >= 5 && c <= 10));
                end
            end
            if (c >= 5 && c <= 10) begin
                checks++;
                if (res_id !== 1'((c - 5) % 2)) begin
                    errors++;
                    $display("FAIL contention_id: after edge %0d res_id=%0d, required %0d", c - 1, res_id, (c - 5) % 2);
                end
            end
            @(posedge clk); #1;             // edge c
            if (c < 5) begin
                if (c % 2 == 0) rand_req0(); else rand_req1();
            end else if (c == 5) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic        held_id;
        logic [7:0]  held_e;
        logic [23:0] held_m;
        res_ready = 1'b1;
        rand_req0(); req0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;             // edge k
            if (k < 2) begin
                rand_req0();
            end else begin
                req0_valid = 1'b0;
                rand_req1(); req1_valid = 1'b1;
            end
        end
        @(posedge clk); #1;                 // edge 3
        res_ready = 1'b0;
        @(negedge clk);
        checks++; if (adr_load !== 1'b1) begin errors++; $display("FAIL bp_pre_load: got %b, required 1", adr_load); end
        held_id = 1'b0; held_e = '0; held_m = '0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);                 // after edge 4+s
            checks++;
            if ({res_valid, adr_load, req0_ready, req1_ready} !== 4'b1000) begin
                errors++;
                $display("FAIL bp_stall: stall cycle %0d valid/load/rdy0/rdy1=%b%b%b%b, required 1000",
                         s, res_valid, adr_load, req0_ready, req1_ready);
            end
            if (s == 0) begin
                held_id = res_id; held_e = res_exp; held_m = res_mant;
                checks++;
                if (res_id !== 1'b0) begin errors++; $display("FAIL bp_first_id: got %0d, required 0", res_id); end
            end else begin
                checks++;
                if ({res_id, res_exp, res_mant} !== {held_id, held_e, held_m}) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got %0d/%h/%h, required %0d/%h/%h",
                             s, res_id, res_exp, res_mant, held_id, held_e, held_m);
                end
            end
        end
        @(posedge clk); #1;                 // edge 7
        res_ready = 1'b1;
        @(negedge clk);
        checks++; if (adr_load !== 1'b1) begin errors++; $display("FAIL bp_release: adr_load=%b, required 1", adr_load); end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_wrap();
        int guard;
        do_reset();
        quiet = 1'b1;
        n_xfer = 0;
        guard = 0;
        req0_exp = 16'h0102; req0_mant = 48'h000010_000020; req0_op = 1'b0;
        req0_valid = 1'b1;
        while (n_xfer < 65535 && guard < 70000) begin
            @(posedge clk); #1;
            guard++;
        end
        req0_valid = 1'b0;
        wait_idle();
        quiet = 1'b0;
        $display("bulk issue of %0d ops complete", n_xfer);
        checks++; if (ops_done !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: ops_done=%h, required ffff", ops_done); end
        rand_req0(); req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_idle();
        checks++; if (ops_done !== 16'h0000) begin errors++; $display("FAIL wrap_rollover: ops_done=%h, required 0000", ops_done); end
    endtask

    task automatic test_reset_flight();
        rand_req0(); req0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;             // edge k
            if (k < 2) begin
                rand_req0();
            end else begin
                req0_valid = 1'b0; clear = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flight_busy_before: got %b, required 1", busy); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flight_res_in_reset: got %b, required 0", res_valid); end
        @(posedge clk); #1;                 // reset edge
        clear = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flight_busy_after: got %b, required 0", busy); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL flight_ghost: cycle %0d res_valid=%b, required 0", i, res_valid);
            end
        end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        clear = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b0; req0_exp = '0; req0_mant = '0; req0_op = 1'b0;
        req1_valid = 1'b0; req1_exp = '0; req1_mant = '0; req1_op = 1'b0;

        test_reset();
        test_single();
        test_op_align();
        test_contention();
        test_backpressure();
        test_wrap();
        test_reset_flight();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d results outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
